// File: rtl/list_walker.sv
// Walks a pointer chain in an async-read memory until END_MARK or MAX_STEPS nodes.
// Latency: N nodes -> done N+1 edges after the start edge; one node per clock.
// Backpressure: none; start is only accepted in IDLE, otherwise dropped.
module list_walker #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_STEPS  = 16,
    parameter logic [DATA_WIDTH-1:0] END_MARK = {DATA_WIDTH{1'b1}},
    localparam int CW = $clog2(MAX_STEPS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] start_addr,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [CW-1:0]         node_count,
    output logic [DATA_WIDTH-1:0] last_addr,
    output logic [DATA_WIDTH-1:0] addr_sum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CW-1:0] LIMIT = CW'(MAX_STEPS);

    state_t        state_q;
    state_t        state_d;
    logic          accept;
    logic          step;
    logic          advance;
    logic          hit_lim;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = node_count + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Terminator is tested first so a chain ending exactly at the limit is not an overflow.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        step    = 1'b0;
        advance = 1'b0;
        hit_lim = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                busy = 1'b1;
                step = 1'b1;
                if (mem_data == END_MARK) begin
                    state_d = DONE;
                end else if (cnt_inc == LIMIT) begin
                    hit_lim = 1'b1;
                    state_d = DONE;
                end else begin
                    advance = 1'b1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr   <= '0;
            node_count <= '0;
            last_addr  <= '0;
            addr_sum   <= '0;
            overflow   <= 1'b0;
        end else if (accept) begin
            mem_addr   <= start_addr;
            node_count <= '0;
            addr_sum   <= '0;
            overflow   <= 1'b0;
        end else if (step) begin
            node_count <= cnt_inc;
            addr_sum   <= addr_sum + mem_addr;
            last_addr  <= mem_addr;
            overflow   <= hit_lim;
            if (advance) begin
                mem_addr <= mem_data;
            end
        end
    end

endmodule
